// File: rtl/vtg_reg_write_arbiter.sv
// Shared register bank with a round-robin write arbiter. One write commits per cycle,
// the winner gets a one-cycle ack, and the whole bank is visible in parallel.
module vtg_reg_slice #(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [SIZE-1:0] d_i,
  output logic [SIZE-1:0] q_o
);
  logic [SIZE-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst)       q_q <= RST_VAL;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module vtg_reg_write_arbiter #(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = '0,
  parameter int              NREQ    = 4,
  parameter int              NREGS   = 4,
  parameter int              AW      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*AW-1:0]       req_addr_i,
  input  logic [NREQ*SIZE-1:0]     req_data_i,
  output logic [NREQ-1:0]          req_ack_o,
  output logic [NREGS*SIZE-1:0]    regs_q_o,
  output logic [$clog2(NREQ)-1:0]  last_grant_o,
  output logic                     addr_err_o,
  output logic [15:0]              wr_count_o
);
  localparam int LGW = $clog2(NREQ);

  logic [NREQ-1:0]             ack_q, ack_d;
  logic                        err_q, err_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [LGW-1:0]              lg_q, lg_d;
  logic [NREQ-1:0]             elig;
  logic                        gnt_vld;
  logic [LGW-1:0]              gnt_idx;
  logic [AW-1:0]               addr_g;
  logic [SIZE-1:0]             data_g;
  logic                        in_rng;
  logic [NREGS-1:0]            we;
  logic [NREGS-1:0][SIZE-1:0]  regs_q;

  // A requester being acked this cycle is masked so a held valid cannot write twice.
  assign elig = req_valid_i & ~ack_q;

  // Walk offsets from farthest to nearest so the nearest eligible requester after
  // the last grant overwrites any earlier pick.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(lg_q) + off) % NREQ;
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = LGW'(idx);
      end
    end
  end

  assign addr_g = req_addr_i[int'(gnt_idx)*AW +: AW];
  assign data_g = req_data_i[int'(gnt_idx)*SIZE +: SIZE];
  assign in_rng = int'(addr_g) < NREGS;

  always_comb begin
    we = '0;
    for (int r = 0; r < NREGS; r++) we[r] = gnt_vld && in_rng && (int'(addr_g) == r);
  end

  always_comb begin
    ack_d = '0;
    err_d = 1'b0;
    cnt_d = cnt_q;
    lg_d  = lg_q;
    if (gnt_vld) begin
      ack_d[gnt_idx] = 1'b1;
      lg_d           = gnt_idx;
      err_d          = ~in_rng;
      if (in_rng && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      lg_q  <= LGW'(NREQ - 1);
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      lg_q  <= lg_d;
    end
  end

  vtg_reg_slice #(.SIZE(SIZE), .RST_VAL(RST_VAL)) u_reg [NREGS-1:0] (
    .clk  (clk),
    .rst  (rst),
    .we_i (we),
    .d_i  (data_g),
    .q_o  (regs_q)
  );

  assign regs_q_o     = regs_q;
  assign req_ack_o    = ack_q;
  assign addr_err_o   = err_q;
  assign wr_count_o   = cnt_q;
  assign last_grant_o = lg_q;
endmodule

// File: tb/tb_vtg_reg_write_arbiter.sv
// Scoreboard bench: a behavioural model predicts each commit when stimulus is driven,
// and the prediction is popped and compared once the edge has happened.
module tb_vtg_reg_write_arbiter;
  localparam int         SIZE  = 8;
  localparam int         NREQ  = 4;
  localparam int         NREGS = 3;
  localparam int         AW    = 2;
  localparam logic [7:0] RV    = 8'h3C;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*SIZE-1:0]   req_data;
  logic [NREQ-1:0]        req_ack;
  logic [NREGS*SIZE-1:0]  regs_q;
  logic [1:0]             last_grant;
  logic                   addr_err;
  logic [15:0]            wr_count;

  vtg_reg_write_arbiter #(.SIZE(SIZE), .RST_VAL(RV), .NREQ(NREQ), .NREGS(NREGS), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ack_o    (req_ack),
    .regs_q_o     (regs_q),
    .last_grant_o (last_grant),
    .addr_err_o   (addr_err),
    .wr_count_o   (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [1:0]            lg;
    logic [15:0]           cnt;
    logic [NREGS*SIZE-1:0] regs;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [NREQ-1:0]       m_ack;
  logic [1:0]            m_lg;
  logic [15:0]           m_cnt;
  logic [NREGS*SIZE-1:0] m_regs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Predict the effect of the coming edge from the inputs now on the pins.
  task automatic predict();
    exp_t            e;
    logic [NREQ-1:0] el;
    logic [AW-1:0]   a;
    logic [SIZE-1:0] d;
    int              g;
    if (rst) begin
      m_regs = {NREGS{RV}};
      m_ack  = '0;
      m_cnt  = '0;
      m_lg   = 2'(NREQ - 1);
      return;
    end
    el = req_valid & ~m_ack;
    g  = -1;
    for (int k = 1; k <= NREQ; k++)
      if (g < 0 && el[(int'(m_lg) + k) % NREQ]) g = (int'(m_lg) + k) % NREQ;
    if (g < 0) begin
      m_ack = '0;
      return;
    end
    a = req_addr[g*AW +: AW];
    d = req_data[g*SIZE +: SIZE];
    e.err = !(int'(a) < NREGS);
    if (!e.err) begin
      m_regs[int'(a)*SIZE +: SIZE] = d;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    m_ack = '0;
    m_ack[g] = 1'b1;
    m_lg  = 2'(g);
    e.ack = m_ack; e.lg = m_lg; e.cnt = m_cnt; e.regs = m_regs;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (q.size() == 0) begin
      chk("idle_ack", 64'(req_ack), 64'(0));
      chk("idle_err", 64'(addr_err), 64'(0));
      chk("idle_regs", 64'(regs_q), 64'(m_regs));
      chk("idle_cnt", 64'(wr_count), 64'(m_cnt));
      chk("idle_lg", 64'(last_grant), 64'(m_lg));
    end else begin
      e = q.pop_front();
      chk("ack", 64'(req_ack), 64'(e.ack));
      chk("err", 64'(addr_err), 64'(e.err));
      chk("regs", 64'(regs_q), 64'(e.regs));
      chk("cnt", 64'(wr_count), 64'(e.cnt));
      chk("lg", 64'(last_grant), 64'(e.lg));
    end
  endtask

  task automatic cyc(input logic r, input logic [NREQ-1:0] v,
                     input logic [NREQ*AW-1:0] a, input logic [NREQ*SIZE-1:0] d);
    rst = r; req_valid = v; req_addr = a; req_data = d;
    predict();
    @(negedge clk);
    check();
  endtask

  localparam logic [NREQ*AW-1:0]   A_ALL = {2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [NREQ*SIZE-1:0] D_ALL = {8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    // Reset held two cycles with all requests pending.
    cyc(1'b1, 4'hF, A_ALL, D_ALL);
    cyc(1'b1, 4'hF, A_ALL, D_ALL);
    chk("rst_regs", 64'(regs_q), 64'({NREGS{RV}}));
    chk("rst_ack", 64'(req_ack), 64'(0));
    chk("rst_cnt", 64'(wr_count), 64'(0));
    chk("rst_lg", 64'(last_grant), 64'(3));

    // Continuous requests rotate 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'hF, A_ALL, D_ALL);
      chk("rr_ack", 64'(req_ack), 64'(1) << (i % 4));
    end
    cyc(1'b0, 4'h0, A_ALL, D_ALL);

    // Single write held through its ack cycle.
    cyc(1'b0, 4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, {8'h00, 8'hA5, 8'h00, 8'h00});
    chk("single_ack", 64'(req_ack), 64'(4'b0100));
    chk("single_reg1", 64'(regs_q[15:8]), 64'(8'hA5));
    cyc(1'b0, 4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, {8'h00, 8'hA5, 8'h00, 8'h00});
    chk("single_noack", 64'(req_ack), 64'(0));
    cyc(1'b0, 4'h0, A_ALL, D_ALL);

    // Out-of-range address.
    cyc(1'b0, 4'b0010, {2'd0, 2'd0, 2'd3, 2'd0}, {8'h00, 8'h00, 8'hEE, 8'h00});
    chk("aerr_pulse", 64'(addr_err), 64'(1));
    chk("aerr_ack", 64'(req_ack), 64'(4'b0010));
    cyc(1'b0, 4'h0, A_ALL, D_ALL);
    chk("aerr_clear", 64'(addr_err), 64'(0));

    // Reset lands on the edge a grant would commit.
    cyc(1'b1, 4'b0010, {2'd0, 2'd0, 2'd2, 2'd0}, {8'h00, 8'h00, 8'h77, 8'h00});
    chk("midrst_ack", 64'(req_ack), 64'(0));
    chk("midrst_lg", 64'(last_grant), 64'(3));
    chk("midrst_regs", 64'(regs_q), 64'({NREGS{RV}}));
    cyc(1'b0, 4'b0010, {2'd0, 2'd0, 2'd2, 2'd0}, {8'h00, 8'h00, 8'h77, 8'h00});
    chk("resume_ack", 64'(req_ack), 64'(4'b0010));
    chk("resume_reg2", 64'(regs_q[23:16]), 64'(8'h77));
    cyc(1'b0, 4'h0, A_ALL, D_ALL);

    // Random traffic, including out-of-range addresses.
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 4'($urandom_range(0, 15)), 8'($urandom), 32'($urandom));

    // Saturation of the write counter.
    for (int i = 0; i < 65540; i++) cyc(1'b0, 4'hF, A_ALL, 32'($urandom));
    chk("sat_cnt", 64'(wr_count), 64'(16'hFFFF));
    cyc(1'b0, 4'hF, A_ALL, D_ALL);
    chk("sat_hold", 64'(wr_count), 64'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
